ir_sensor_filter: RTL and testbench
===================================

// Module: ir_sensor_filter
// PURPOSE
//  Conditions the three raw IR obstacle sensors (front, right, left) for the motor drive stage.
//  Each raw input is synchronised, sampled on a slow tick and debounced.
//  The debounced levels drive the motor drive's fir/rir/lir inputs, with the same polarity as the raw inputs.
//  After reset, all three outputs are held at 1 (motor drive "all stop") until a warm-up period completes.
// PARAMETERS
//  TICK_DIV      500  clk cycles per sample tick (>=2); prescaler counts 0..TICK_DIV-1
//  STABLE_TICKS  8    consecutive differing ticks required to accept a new level (>=2)
// PORTS
//  clk      in   1  system clock, all logic on posedge
//  rst      in   1  asynchronous, active-high reset
//  fir_raw  in   1  raw front IR sensor, asynchronous to clk
//  rir_raw  in   1  raw right IR sensor, asynchronous to clk
//  lir_raw  in   1  raw left IR sensor, asynchronous to clk
//  fir      out  1  debounced front level to motor drive
//  rir      out  1  debounced right level to motor drive
//  lir      out  1  debounced left level to motor drive
//  ready    out  1  1 once warm-up done and outputs track filtered sensors
//  change   out  1  1-clk pulse when {fir,rir,lir} differs from previous cycle
// BEHAVIOUR
//  Reset: sync flops=1, filtered levels=1, debounce counters=0, prescaler=0, FSM=WARMUP.
//   fir=rir=lir=1, ready=0, change=0.
//  Sync: 2-flop synchroniser per input; reset value 1.
//  Prescaler: increments every clk; tick=1 for one clk when count==TICK_DIV-1, count then wraps to 0.
//  Debounce, per channel, evaluated only on tick cycles:
//   - sync == filt: counter cleared to 0.
//   - sync != filt and counter < STABLE_TICKS-1: counter += 1.
//   - sync != filt and counter == STABLE_TICKS-1: filt <= sync, counter <= 0.
//   - A single matching sample clears the counter, so isolated glitches never propagate.
//   - Counter width is $clog2(STABLE_TICKS) and never exceeds STABLE_TICKS-1.
//   - The three channels are fully independent; simultaneous changes update on the same tick.
//  FSM:
//   - WARMUP: the filters run normally; outputs forced to 1; ready=0.
//     Warm-up counter increments on each tick. After STABLE_TICKS ticks, the FSM goes to RUN on that tick edge.
//   - RUN: {fir,rir,lir} <= filt registers (one register stage); ready=1. RUN persists until rst.
//  Outputs are registered. A filt update is visible on the outputs one clk later.
//  Latency: a raw level held stable reaches the output between (STABLE_TICKS-1)*TICK_DIV+4
//   and STABLE_TICKS*TICK_DIV+4 clks after the raw edge, depending on prescaler phase.
//  change: registered compare of current vs previous {fir,rir,lir}, so it is high the clk after the outputs move.
//   Also fires at the WARMUP->RUN handoff if any filtered level is 0.
//  Reset mid-operation: all state returns to reset values immediately (async).
//   WARMUP restarts and outputs return to 1 (stop) with no glitch to 0.
// TESTING  (sim params TICK_DIV=4, STABLE_TICKS=3)
//  1. Assert rst, raws=0 -> fir=rir=lir=1, ready=0, change=0.
//     Release -> ready rises 12 clks (+/- 1 clk) after release.
//     Outputs then go 0 with a single change pulse.
//  2. In RUN, hold all raws=1, drop rir_raw to 0 and hold.
//     -> rir goes 0 within 8..12+4 clks; fir, lir stay 1; exactly one change pulse.
//  3. rir_raw low for 6 clks, then back high (covers <3 ticks) -> rir stays 1; change never pulses.
//  4. rir_raw 0/1 alternating every tick for 40 clks -> rir never changes; counter never exceeds 2.
//  5. Drop fir_raw and lir_raw on the same clk -> fir and lir fall on the same clk; one change pulse.
//  6. Assert rst for 1 clk while in RUN with rir=0 -> rir=1 and ready=0 at once.
//     Full warm-up is repeated before rir returns to 0.

Source files
------------

// File: rtl/ir_sensor_filter.sv
// ---------------------------------------------------------------------------
// ir_sensor_filter
//   Conditions the three raw IR obstacle sensors (front, right, left) for the
//   motor drive stage. Each raw input is synchronised, sampled on a slow
//   prescaler tick and debounced. While the block warms up after reset, all
//   outputs are held at 1 ("all stop"). After warm-up they track the debounced
//   levels with the same polarity as the raw inputs.
//
// Ports
//   clk      in   system clock, all logic on posedge
//   rst      in   asynchronous, active-high reset
//   fir_raw  in   raw front IR sensor (asynchronous to clk)
//   rir_raw  in   raw right IR sensor (asynchronous to clk)
//   lir_raw  in   raw left IR sensor (asynchronous to clk)
//   fir      out  debounced front level
//   rir      out  debounced right level
//   lir      out  debounced left level
//   ready    out  1 once warm-up is done and outputs track the filters
//   change   out  1-clk pulse the cycle after {fir,rir,lir} moves
// ---------------------------------------------------------------------------
module ir_sensor_filter #(
    parameter int TICK_DIV     = 500,
    parameter int STABLE_TICKS = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic fir_raw,
    input  logic rir_raw,
    input  logic lir_raw,
    output logic fir,
    output logic rir,
    output logic lir,
    output logic ready,
    output logic change
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int CW = $clog2(STABLE_TICKS);

    typedef enum logic {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } state_t;

    // Channel order everywhere: [2]=front, [1]=right, [0]=left
    logic [2:0]    raw;
    logic [2:0]    sync1_q, sync1_d;
    logic [2:0]    sync2_q, sync2_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          tick;
    logic [2:0]    filt_q, filt_d;
    logic [CW-1:0] cnt_q [3];
    logic [CW-1:0] cnt_d [3];
    logic [CW-1:0] warm_q, warm_d;
    state_t        state_q, state_d;
    logic [2:0]    out_q, out_d;
    logic [2:0]    prev_q, prev_d;
    logic          change_q, change_d;

    assign raw = {fir_raw, rir_raw, lir_raw};

    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;

        tick    = (presc_q == PW'(TICK_DIV - 1));
        presc_d = tick ? '0 : presc_q + PW'(1);

        // Debounce: a new level needs STABLE_TICKS consecutive differing
        // samples; any matching sample restarts the count.
        filt_d = filt_q;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = cnt_q[i];
            if (tick) begin
                if (sync2_q[i] == filt_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CW'(STABLE_TICKS - 1)) begin
                    filt_d[i] = sync2_q[i];
                    cnt_d[i]  = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end

        // Warm-up lasts STABLE_TICKS ticks; RUN is sticky until reset.
        state_d = state_q;
        warm_d  = warm_q;
        if (state_q == WARMUP && tick) begin
            if (warm_q == CW'(STABLE_TICKS - 1)) begin
                state_d = RUN;
                warm_d  = '0;
            end else begin
                warm_d = warm_q + CW'(1);
            end
        end

        out_d    = (state_q == RUN) ? filt_q : 3'b111;
        prev_d   = out_q;
        // Compares against the previous output, so the pulse lands the
        // cycle after the outputs move.
        change_d = (out_q != prev_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 3'b111;
            sync2_q  <= 3'b111;
            presc_q  <= '0;
            filt_q   <= 3'b111;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
            warm_q   <= '0;
            state_q  <= WARMUP;
            out_q    <= 3'b111;
            prev_q   <= 3'b111;
            change_q <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            presc_q  <= presc_d;
            filt_q   <= filt_d;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            warm_q   <= warm_d;
            state_q  <= state_d;
            out_q    <= out_d;
            prev_q   <= prev_d;
            change_q <= change_d;
        end
    end

    assign fir    = out_q[2];
    assign rir    = out_q[1];
    assign lir    = out_q[0];
    assign ready  = (state_q == RUN);
    assign change = change_q;

endmodule

// File: tb/tb_ir_sensor_filter.sv
// ---------------------------------------------------------------------------
// tb_ir_sensor_filter
//   Self-checking bench for ir_sensor_filter with TICK_DIV=4, STABLE_TICKS=3.
//   Hand-written sequences cover reset, warm-up timing, latency, glitch
//   rejection, simultaneous edges and mid-run reset; a vector table drives
//   steady-state raw patterns through a scoreboard queue.
// ---------------------------------------------------------------------------
module tb_ir_sensor_filter;

    localparam int TD = 4;
    localparam int ST = 3;

    logic clk = 1'b0;
    logic rst;
    logic fir_raw, rir_raw, lir_raw;
    logic fir, rir, lir, ready, change;
    logic [2:0] outs;

    assign outs = {fir, rir, lir};

    always #5 clk = ~clk;

    ir_sensor_filter #(.TICK_DIV(TD), .STABLE_TICKS(ST)) dut (
        .clk     (clk),
        .rst     (rst),
        .fir_raw (fir_raw),
        .rir_raw (rir_raw),
        .lir_raw (lir_raw),
        .fir     (fir),
        .rir     (rir),
        .lir     (lir),
        .ready   (ready),
        .change  (change)
    );

    // Monotonic event counters, sampled on the falling edge.
    int chg_cnt    = 0;
    int rir_low    = 0;
    int warm_glitch = 0;

    always @(negedge clk) begin
        if (change === 1'b1) chg_cnt++;
        if (rir === 1'b0) rir_low++;
        if (ready !== 1'b1 && outs !== 3'b111) warm_glitch++;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0] raw;
        logic [2:0] exp_out;
        int         exp_chg;
    } vec_t;

    vec_t tbl[6];
    vec_t sb[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int l0;
        int n;
        int rdy_n;
        vec_t v;

        // Expected outputs follow the raw pattern; change count is 1 when
        // the outputs move from the previous entry (all bits move together).
        tbl[0] = '{3'b111, 3'b111, 1};
        tbl[1] = '{3'b000, 3'b000, 1};
        tbl[2] = '{3'b101, 3'b101, 1};
        tbl[3] = '{3'b101, 3'b101, 0};
        tbl[4] = '{3'b010, 3'b010, 1};
        tbl[5] = '{3'b111, 3'b111, 1};

        // ---- 1. reset state and warm-up ----
        rst = 1'b1;
        fir_raw = 1'b0; rir_raw = 1'b0; lir_raw = 1'b0;
        step(3);
        check("reset_outs", int'(outs), 3'b111);
        check("reset_ready", int'(ready), 0);
        check("reset_change", int'(change), 0);

        rst = 1'b0;
        n = 0;
        while (ready !== 1'b1 && n < 40) begin
            step(1);
            n++;
        end
        check("warmup_ready_in_window", int'(n >= 11 && n <= 13), 1);
        check("warmup_outs_still_stop", int'(outs), 3'b111);
        step(1);
        c0 = chg_cnt;
        check("warmup_outs_low", int'(outs), 3'b000);
        step(4);
        check("warmup_change_pulses", chg_cnt - c0, 1);

        // ---- 2. rir falls in RUN ----
        fir_raw = 1'b1; rir_raw = 1'b1; lir_raw = 1'b1;
        step(24);
        check("run_all_high", int'(outs), 3'b111);
        c0 = chg_cnt;
        rir_raw = 1'b0;
        n = 0;
        while (rir !== 1'b0 && n < 30) begin
            step(1);
            n++;
        end
        check("rir_fall_latency_window", int'(n >= (ST-1)*TD+4 && n <= ST*TD+4), 1);
        check("rir_fall_others", int'({fir, lir}), 2'b11);
        step(3);
        check("rir_fall_change_pulses", chg_cnt - c0, 1);

        // ---- 3. short low pulse is rejected ----
        rir_raw = 1'b1;
        step(24);
        check("rir_recovered", int'(rir), 1);
        c0 = chg_cnt;
        l0 = rir_low;
        rir_raw = 1'b0;
        step(6);
        rir_raw = 1'b1;
        step(30);
        check("short_pulse_rir_low", rir_low - l0, 0);
        check("short_pulse_change", chg_cnt - c0, 0);

        // ---- 4. alternating every tick ----
        c0 = chg_cnt;
        l0 = rir_low;
        for (int i = 0; i < 10; i++) begin
            rir_raw = (i % 2 == 0) ? 1'b0 : 1'b1;
            step(TD);
        end
        step(20);
        check("alternate_rir_low", rir_low - l0, 0);
        check("alternate_change", chg_cnt - c0, 0);

        // ---- 5. fir and lir drop together ----
        c0 = chg_cnt;
        fir_raw = 1'b0;
        lir_raw = 1'b0;
        n = 0;
        while (fir !== 1'b0 && lir !== 1'b0 && n < 30) begin
            step(1);
            n++;
        end
        check("simul_fall_latency_window", int'(n >= (ST-1)*TD+4 && n <= ST*TD+4), 1);
        check("simul_fall_outs", int'(outs), 3'b010);
        step(3);
        check("simul_fall_change_pulses", chg_cnt - c0, 1);

        // ---- table-driven steady-state patterns via scoreboard ----
        for (int i = 0; i < 6; i++) begin
            {fir_raw, rir_raw, lir_raw} = tbl[i].raw;
            sb.push_back(tbl[i]);
            c0 = chg_cnt;
            step(24);
            v = sb.pop_front();
            check($sformatf("vec%0d_outs", i), int'(outs), int'(v.exp_out));
            check($sformatf("vec%0d_change", i), chg_cnt - c0, v.exp_chg);
        end

        // ---- 6. reset while in RUN with rir low ----
        fir_raw = 1'b1; rir_raw = 1'b0; lir_raw = 1'b1;
        step(24);
        check("pre_reset_outs", int'(outs), 3'b101);
        check("pre_reset_ready", int'(ready), 1);
        rst = 1'b1;
        #1;
        check("async_reset_outs", int'(outs), 3'b111);
        check("async_reset_ready", int'(ready), 0);
        step(1);
        rst = 1'b0;
        n = 0;
        rdy_n = -1;
        while (rir !== 1'b0 && n < 40) begin
            step(1);
            n++;
            if (ready === 1'b1 && rdy_n < 0) rdy_n = n;
        end
        check("rewarm_ready_in_window", int'(rdy_n >= 11 && rdy_n <= 13), 1);
        check("rewarm_rir_low_after_ready", n, rdy_n + 1);
        check("no_low_output_during_warmup", warm_glitch, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
